systolic_array_4x4: RTL and testbench
=====================================

// Module: systolic_array_4x4
// PURPOSE
//  Output-stationary N x N systolic matrix-multiply array (default 4x4).
//  Two skewed operand streams enter at the array edges: a from the left, b from the top.
//  Each processing element (PE) multiply-accumulates its in-place sum.
//  All N*N accumulators are exposed flat on result; the block is the compute core behind the feeder logic.
// PARAMETERS
//  N       4   array dimension (rows = cols = lanes)
//  DATA_W  16  operand width, unsigned
//  ACC_W   32  accumulator / result element width, unsigned
// PORTS
//  clk     in   1            single clock, all state updates on rising edge
//  rst     in   1            asynchronous, active-high reset
//  a       in   N*DATA_W     lane i = a[(i+1)*DATA_W-1 -: DATA_W], feeds array row i
//  b       in   N*DATA_W     lane j = b[(j+1)*DATA_W-1 -: DATA_W], feeds array column j
//  result  out  N*N*ACC_W    PE(i,j) acc = result[(N*i+j+1)*ACC_W-1 -: ACC_W]
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset:
//    - All accumulators and all forwarded a/b pipeline registers clear to 0 immediately.
//    - result = 0 while rst is high.
//  - Every rising edge (rst low), for each PE(i,j):
//      acc   <= acc + a_in*b_in
//      a_out <= a_in   (passes right)
//      b_out <= b_in   (passes down)
//  - PE inputs:
//    - PE(i,0).a_in = lane i of a, unregistered.
//    - PE(0,j).b_in = lane j of b, unregistered.
//    - Other PEs take the neighbour's registered a_out / b_out.
//    - Hence PE(i,j) sees lane i delayed j cycles and lane j delayed i cycles.
//  - Arithmetic:
//    - Unsigned; product DATA_W x DATA_W -> 2*DATA_W bits, zero-extended or truncated to ACC_W.
//    - Accumulation wraps modulo 2^ACC_W; no saturation, no overflow flag.
//  - No clear/valid/handshake: accumulators integrate forever until reset.
//    - A zero on either operand contributes nothing; the feeder drives idle lanes to 0.
//  - result is combinational from the accumulator registers; no extra output stage.
//  - Feeding convention used by the system, with steps s = 0..2N-2 applied on successive edges:
//      a lane k = A[N-1-s+k][k]
//      b lane k = B[k][N-1-s+k]
//      (lane = 0 when the index is out of 0..N-1)
//    This yields acc(i,j) = sum_m A[m][i]*B[j][m] = (B*A)[j][i].
//  - Latency: the last product lands in PE(N-1,N-1) on edge 3N-3 after step 0 (edge 9 for N=4).
//    All results are stable from that edge on while inputs stay 0.
//  - Reset mid-operation: everything clears at once. Partially injected data is lost and the feeder must restart at step 0.
//  - X or undriven inputs are the feeder's responsibility; no masking in the array.
// STRUCTURE
//  - Package systolic_pkg: N, DATA_W, ACC_W defaults and a result-index helper function.
//  - One sub-module, systolic_pe:
//    - Ports clk, rst, a_in, b_in, a_out, b_out, acc.
//    - Instantiated N*N times with generate loops.
//  - Top-level holds only wiring: horizontal a nets, vertical b nets, result packing.
// TESTING
//  1. Reset: rst=1 with nonzero a/b -> result all 0. Assert rst between edges -> clears with no clock edge.
//  2. Skewed 4x4 run with A=B=[[1..4],[5..8],[9..12],[13..16]], steps 0..6 then zeros.
//     After edge 9 the result rows are:
//       [90 202 314 426]
//       [100 228 356 484]
//       [110 254 398 542]
//       [120 280 440 600]
//  3. Single pulse a lane0=3, b lane0=5 for one edge, then zeros -> only PE(0,0)=15.
//     Confirms forwarding: PE(0,1), PE(1,0) and all other PEs stay 0.
//  4. Constant a=all 1, b=all 1 for 10 edges -> PE(i,j) = 10-max(i,j) (PE(0,0)=10, PE(3,3)=7).
//  5. Overflow: a lane0=b lane0=0xFFFF held 2 edges -> PE(0,0) = 2*0xFFFE0001 mod 2^32 = 0xFFFC0002.
//  6. Reset mid-run (rst high at step 3) then rerun scenario 2 -> identical final matrix.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared dimensions for the output-stationary systolic array and a helper that
// maps a PE coordinate onto its slot in the flat result bus.
package systolic_pkg;

    localparam int SYS_N      = 4;
    localparam int SYS_DATA_W = 16;
    localparam int SYS_ACC_W  = 32;

    // PE(row,col) occupies element n*row+col of the flattened result
    function automatic int resultIndex(input int n, input int row, input int col);
        return n * row + col;
    endfunction

endpackage

// File: rtl/systolic_array_4x4_if.sv
// Operand lanes into the array and the flattened accumulator matrix out of it.
// The feeder drives a/b as master; the array consumes them as slave.
interface systolic_array_4x4_if
    import systolic_pkg::*;
#(
    parameter int N      = SYS_N,
    parameter int DATA_W = SYS_DATA_W,
    parameter int ACC_W  = SYS_ACC_W
);

    logic [N*DATA_W-1:0]  a;
    logic [N*DATA_W-1:0]  b;
    logic [N*N*ACC_W-1:0] result;

    modport master (output a, output b, input result);
    modport slave  (input a, input b, output result);

endinterface

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell: integrates a_in*b_in forever and forwards both
// operands one cycle later to its right and lower neighbours.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = SYS_DATA_W,
    parameter int ACC_W  = SYS_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_term;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [ACC_W-1:0]  r_acc;

    // Full-width product, then fitted to the accumulator; the sum wraps freely
    assign w_prod = PROD_W'(a_in) * PROD_W'(b_in);
    assign w_term = ACC_W'(w_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_acc <= r_acc + w_term;
        end
    end

    assign a_out = r_a;
    assign b_out = r_b;
    assign acc   = r_acc;

endmodule

// File: rtl/systolic_array_4x4.sv
// N x N grid of systolic_pe cells: a flows left-to-right, b flows top-to-bottom,
// and every accumulator is exposed directly on the flat result bus.
module systolic_array_4x4
    import systolic_pkg::*;
#(
    parameter int N      = SYS_N,
    parameter int DATA_W = SYS_DATA_W,
    parameter int ACC_W  = SYS_ACC_W
) (
    input logic                  clk,
    input logic                  rst,
    systolic_array_4x4_if.slave  bus
);

    // Column N of w_a and row N of w_b are the unused outputs of the far edge
    logic [DATA_W-1:0] w_a   [N][N+1];
    logic [DATA_W-1:0] w_b   [N+1][N];
    logic [ACC_W-1:0]  w_acc [N][N];

    for (genvar k = 0; k < N; k++) begin : g_edge
        assign w_a[k][0] = bus.a[(k+1)*DATA_W-1 -: DATA_W];
        assign w_b[0][k] = bus.b[(k+1)*DATA_W-1 -: DATA_W];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .a_in  (w_a[i][j]),
                .b_in  (w_b[i][j]),
                .a_out (w_a[i][j+1]),
                .b_out (w_b[i+1][j]),
                .acc   (w_acc[i][j])
            );
        end
    end

    always_comb begin
        bus.result = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                bus.result[resultIndex(N, i, j)*ACC_W +: ACC_W] = w_acc[i][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Self-checking bench for systolic_array_4x4: directed scenarios plus random
// streams, compared against a lane-delay model of the array.
module tb_systolic_array_4x4;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    logic clk;
    logic rst;

    systolic_array_4x4_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    systolic_array_4x4 #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount;
    int passCount;

    // Reference model: history of everything fed since the last reset.
    // PE(i,j) sees lane i of a delayed j edges and lane j of b delayed i edges.
    logic [N*DATA_W-1:0] aHist[$];
    logic [N*DATA_W-1:0] bHist[$];
    logic [ACC_W-1:0]    expAcc[N][N];

    int matA[N][N];
    int goldenProd[N][N];
    int goldenOnes[N][N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DATA_W-1:0] laneOf(input logic [N*DATA_W-1:0] v, input int k);
        return v[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [ACC_W-1:0] resultAt(input int i, input int j);
        return bus.result[(N*i+j)*ACC_W +: ACC_W];
    endfunction

    task automatic checkOutput(input string tag, input logic [ACC_W-1:0] observed,
                               input logic [ACC_W-1:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic clearModel();
        aHist.delete();
        bHist.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                expAcc[i][j] = '0;
    endtask

    // One edge worth of model integration, using only the lane-delay rule
    task automatic modelEdge(input logic [N*DATA_W-1:0] aVec, input logic [N*DATA_W-1:0] bVec);
        int t;
        longint unsigned prod;
        aHist.push_back(aVec);
        bHist.push_back(bVec);
        t = aHist.size() - 1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (t - j >= 0 && t - i >= 0) begin
                    prod = longint'(laneOf(aHist[t-j], i)) * longint'(laneOf(bHist[t-i], j));
                    expAcc[i][j] = expAcc[i][j] + ACC_W'(prod);
                end
            end
        end
    endtask

    // Entered and left on a falling edge; the new lanes are captured by the next rising edge
    task automatic applyStimulus(input logic [N*DATA_W-1:0] aVec, input logic [N*DATA_W-1:0] bVec);
        bus.a = aVec;
        bus.b = bVec;
        @(posedge clk);
        modelEdge(aVec, bVec);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearModel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("%s(%0d,%0d)", tag, i, j), resultAt(i, j), expAcc[i][j]);
    endtask

    task automatic checkZero(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("%s(%0d,%0d)", tag, i, j), resultAt(i, j), '0);
    endtask

    // Feeder convention: a lane k = A[N-1-s+k][k], b lane k = B[k][N-1-s+k]
    task automatic feedStep(input int s);
        logic [N*DATA_W-1:0] aVec;
        logic [N*DATA_W-1:0] bVec;
        int idx;
        aVec = '0;
        bVec = '0;
        for (int k = 0; k < N; k++) begin
            idx = N - 1 - s + k;
            if (idx >= 0 && idx < N) begin
                aVec[k*DATA_W +: DATA_W] = DATA_W'(matA[idx][k]);
                bVec[k*DATA_W +: DATA_W] = DATA_W'(matA[k][idx]);
            end
        end
        applyStimulus(aVec, bVec);
    endtask

    task automatic runSkewed(input string tag);
        for (int s = 0; s <= 2*N-2; s++)
            feedStep(s);
        for (int e = 0; e < 4; e++)
            applyStimulus('0, '0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("%s_gold(%0d,%0d)", tag, i, j), resultAt(i, j),
                            ACC_W'(goldenProd[i][j]));
        checkAll({tag, "_model"});
    endtask

    initial begin
        logic [N*DATA_W-1:0] aVec;
        logic [N*DATA_W-1:0] bVec;
        logic [N*DATA_W-1:0] onesVec;

        checkCount = 0;
        passCount  = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                matA[r][c] = N*r + c + 1;
        goldenProd = '{'{90, 202, 314, 426}, '{100, 228, 356, 484},
                       '{110, 254, 398, 542}, '{120, 280, 440, 600}};
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                goldenOnes[i][j] = 10 - ((i > j) ? i : j);

        // Reset held with live operands keeps everything at zero
        rst   = 1'b1;
        bus.a = {$urandom, $urandom} | 64'h0001_0001_0001_0001;
        bus.b = {$urandom, $urandom} | 64'h0001_0001_0001_0001;
        clearModel();
        repeat (3) @(negedge clk);
        checkZero("rstHeld");
        rst = 1'b0;

        // Asynchronous clear between edges
        for (int e = 0; e < 3; e++)
            applyStimulus(64'h0002_0003_0004_0005, 64'h0005_0004_0003_0002);
        checkOutput("preAsync(0,0)", resultAt(0, 0), expAcc[0][0]);
        #2 rst = 1'b1;
        #1 checkZero("asyncRst");
        clearModel();
        @(negedge clk);
        rst = 1'b0;

        runSkewed("skew");

        // Single pulse must stay in PE(0,0)
        doReset();
        applyStimulus(64'h3, 64'h5);
        for (int e = 0; e < 8; e++)
            applyStimulus('0, '0);
        checkOutput("pulse(0,0)", resultAt(0, 0), 32'd15);
        checkOutput("pulse(0,1)", resultAt(0, 1), 32'd0);
        checkOutput("pulse(1,0)", resultAt(1, 0), 32'd0);
        checkAll("pulse");

        // Constant ones for ten edges
        doReset();
        onesVec = '0;
        for (int k = 0; k < N; k++)
            onesVec[k*DATA_W +: DATA_W] = 16'd1;
        for (int e = 0; e < 10; e++)
            applyStimulus(onesVec, onesVec);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("ones(%0d,%0d)", i, j), resultAt(i, j),
                            ACC_W'(goldenOnes[i][j]));
        bus.a = '0;
        bus.b = '0;

        // Accumulator wrap
        doReset();
        applyStimulus(64'hFFFF, 64'hFFFF);
        applyStimulus(64'hFFFF, 64'hFFFF);
        checkOutput("wrap(0,0)", resultAt(0, 0), 32'hFFFC_0002);
        applyStimulus('0, '0);
        checkAll("wrap");

        // Reset in the middle of a skewed feed, then a clean rerun
        doReset();
        for (int s = 0; s < 3; s++)
            feedStep(s);
        #2 rst = 1'b1;
        #1 checkZero("midRst");
        clearModel();
        @(negedge clk);
        rst = 1'b0;
        runSkewed("rerun");

        // Random streams, including sparse idle lanes
        for (int round = 0; round < 4; round++) begin
            doReset();
            for (int e = 0; e < 15; e++) begin
                aVec = {$urandom, $urandom};
                bVec = {$urandom, $urandom};
                if (round[0]) begin
                    for (int k = 0; k < N; k++) begin
                        if ($urandom_range(0, 2) == 0) aVec[k*DATA_W +: DATA_W] = '0;
                        if ($urandom_range(0, 2) == 0) bVec[k*DATA_W +: DATA_W] = '0;
                    end
                end
                applyStimulus(aVec, bVec);
            end
            checkAll($sformatf("rand%0d", round));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
